ha_cfg_sequencer: RTL and testbench
===================================

HA_CFG_SEQUENCER -- requirements
Module: ha_cfg_sequencer

Interface
REQ-001 Parameters SHALL be:
- DEPTH, 8, number of program slots (power of two)
- INST_BW, 3, config instruction width (mux-select word)
- SEL_BW, 3, global-input select width
- HOLD_BW, 4, per-step hold-count width
- LAT, 1, datapath pipeline latency in cycles (>=1)
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- prog_we  in  1  program-table write strobe
- prog_addr  in  log2(DEPTH)  table write address
- prog_data  in  INST_BW+SEL_BW+HOLD_BW  step entry {inst, sel, hold}, inst in MSBs
- prog_len  in  log2(DEPTH)+1  number of steps to execute, 0..DEPTH
- start  in  1  begin program execution
- abort  in  1  terminate execution
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- cfg_en  out  1  config-register load enable to datapath
- cfg_inst  out  INST_BW  config-register instruction word
- global_sel  out  SEL_BW  per-input global/local selects (bit i drives input i)
- step_idx  out  log2(DEPTH)  index of the current step
- capture  out  1  datapath result valid this cycle

Function
REQ-003 Program table SHALL be DEPTH entries, written on a clk edge when prog_we=1 and busy=0; prog_we while busy=1 SHALL be ignored.
REQ-004 The FSM SHALL have states IDLE, LOAD, RUN, DONE; busy SHALL be 1 in LOAD and RUN only.
REQ-005 IDLE: start=1 with prog_len in 1..DEPTH -> LOAD, step_idx=0; start with prog_len=0 or prog_len>DEPTH SHALL be ignored (stay IDLE, no done).
REQ-006 LOAD (exactly 1 cycle): cfg_en=1, cfg_inst=entry[step_idx].inst, global_sel=entry[step_idx].sel, all registered; hold counter loaded with max(entry.hold, LAT); -> RUN.
REQ-007 RUN: counter decrements each cycle; capture=1 only on the cycle counter==0; RUN length = max(hold,LAT)+1 cycles.
REQ-008 On RUN exit: if step_idx==prog_len-1 -> DONE, else step_idx+1 -> LOAD.
REQ-009 DONE (1 cycle): done=1, cfg_en=0; -> IDLE; start in DONE SHALL be ignored.
REQ-010 cfg_en SHALL be 0 in every state except LOAD; capture SHALL be 0 outside RUN.
REQ-011 cfg_inst and global_sel SHALL hold their last loaded values in RUN, DONE and IDLE until the next LOAD or reset.
REQ-012 abort=1 in LOAD or RUN SHALL force IDLE next cycle: cfg_en=0, capture=0, done not asserted, step_idx=0; abort has priority over all transitions; abort in IDLE/DONE SHALL have no effect.
REQ-013 start=1 while busy=1 SHALL be ignored.
REQ-014 Back-to-back steps SHALL incur no idle gap: RUN exit cycle is followed directly by LOAD.
REQ-015 Total cycles from start edge to done pulse SHALL be sum over steps of (max(hold,LAT)+2) plus 1.

Reset
REQ-016 rst=1 SHALL asynchronously force IDLE and drive busy, done, cfg_en, capture, cfg_inst, global_sel, step_idx to 0.
REQ-017 rst SHALL clear all program-table entries to 0.
REQ-018 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse; first start after release SHALL begin at step 0.

Verification
REQ-019 Single step: entry0={inst=3'b101,sel=3'b010,hold=2}, prog_len=1, start -> cfg_en=1 one cycle with cfg_inst=101, global_sel=010; capture on 3rd RUN cycle; done 1 cycle later; 5 cycles start-to-done.
REQ-020 Three steps, hold=0 each, LAT=1, inst=001/010/100 -> cfg_en pulses every 3 cycles, step_idx 0,1,2, three capture pulses, done at cycle 10.
REQ-021 Abort: 4-step program, abort during step 1 RUN -> IDLE next cycle, no done, step_idx=0, cfg_inst retains step-1 value.
REQ-022 Guard: start with prog_len=0 -> busy stays 0, no done; prog_we during busy -> table entry unchanged on readback run.
REQ-023 Async reset mid-RUN (between edges) -> all outputs 0 immediately; restart with new program of length 1 completes normally with table reloaded.
REQ-024 Full table: prog_len=8, hold=15 each -> step_idx wraps 7 then done, 8 captures, 137 cycles start-to-done.

Source files
------------

// File: rtl/ha_cfg_sequencer.sv
// Configuration sequencer: steps through a small program table, loading a
// config word and global selects per step, then waits out the step's hold time.
module ha_cfg_sequencer #(
  parameter int DEPTH   = 8,
  parameter int INST_BW = 3,
  parameter int SEL_BW  = 3,
  parameter int HOLD_BW = 4,
  parameter int LAT     = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              prog_we,
  input  logic [$clog2(DEPTH)-1:0]          prog_addr,
  input  logic [INST_BW+SEL_BW+HOLD_BW-1:0] prog_data,
  input  logic [$clog2(DEPTH):0]            prog_len,
  input  logic                              start,
  input  logic                              abort,
  output logic                              busy,
  output logic                              done,
  output logic                              cfg_en,
  output logic [INST_BW-1:0]                cfg_inst,
  output logic [SEL_BW-1:0]                 global_sel,
  output logic [$clog2(DEPTH)-1:0]          step_idx,
  output logic                              capture
);

  localparam int AW    = $clog2(DEPTH);
  localparam int EW    = INST_BW + SEL_BW + HOLD_BW;
  localparam int LAT_W = $clog2(LAT + 1);
  localparam int CW    = (HOLD_BW > LAT_W) ? HOLD_BW : LAT_W;

  localparam logic [CW-1:0] LAT_C   = CW'(LAT);
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [AW-1:0] IDX_ONE = 1;
  localparam logic [AW:0]   LEN_ONE = 1;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [EW-1:0]       table_rd [DEPTH];
  logic [AW-1:0]       step_idx_q, step_idx_d;
  logic [AW:0]         len_q, len_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [INST_BW-1:0]  inst_q, inst_d;
  logic [SEL_BW-1:0]   sel_q, sel_d;

  logic                start_ok;
  logic                last_step;
  logic                run_end;
  logic [AW-1:0]       nxt_idx;
  logic [HOLD_BW-1:0]  cur_hold;
  logic [CW-1:0]       hold_eff;

  // Program table: one register per slot so reset can clear every entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
    logic [EW-1:0] entry_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entry_q <= '0;
      end else if (prog_we && !busy && (prog_addr == AW'(gi))) begin
        entry_q <= prog_data;
      end
    end
    assign table_rd[gi] = entry_q;
  end

  assign start_ok  = start && (prog_len != '0) && (prog_len <= DEPTH_C);
  assign last_step = ({1'b0, step_idx_q} == (len_q - LEN_ONE));
  assign run_end   = (cnt_q == '0);
  assign nxt_idx   = (state_q == S_IDLE) ? '0 : (step_idx_q + IDX_ONE);
  assign cur_hold  = table_rd[step_idx_q][HOLD_BW-1:0];
  assign hold_eff  = (CW'(cur_hold) < LAT_C) ? LAT_C : CW'(cur_hold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_LOAD;
      S_LOAD: state_d = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (run_end) begin
          state_d = last_step ? S_DONE : S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    cfg_en  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_LOAD: begin
        busy   = 1'b1;
        cfg_en = 1'b1;
      end
      S_RUN: begin
        busy    = 1'b1;
        capture = run_end;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Step registers; the config word is captured on the edge entering LOAD.
  always_comb begin
    step_idx_d = step_idx_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    inst_d     = inst_q;
    sel_d      = sel_q;
    if ((state_q == S_IDLE) && start_ok) begin
      len_d = prog_len;
    end
    if (state_d == S_LOAD) begin
      step_idx_d = nxt_idx;
      inst_d     = table_rd[nxt_idx][EW-1 -: INST_BW];
      sel_d      = table_rd[nxt_idx][HOLD_BW +: SEL_BW];
    end
    if ((state_q == S_LOAD) && !abort) begin
      cnt_d = hold_eff;
    end else if ((state_q == S_RUN) && !run_end) begin
      cnt_d = cnt_q - CNT_ONE;
    end
    if (busy && abort) begin
      step_idx_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_idx_q <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      inst_q     <= '0;
      sel_q      <= '0;
    end else begin
      step_idx_q <= step_idx_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      inst_q     <= inst_d;
      sel_q      <= sel_d;
    end
  end

  assign cfg_inst   = inst_q;
  assign global_sel = sel_q;
  assign step_idx   = step_idx_q;

endmodule

// File: tb/tb_ha_cfg_sequencer.sv
// Randomized bench for ha_cfg_sequencer: expected per-cycle outputs are built
// from the program contents (step lengths, capture points, done timing).
module tb_ha_cfg_sequencer;

  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       prog_we = 1'b0;
  logic [2:0] prog_addr = '0;
  logic [9:0] prog_data = '0;
  logic [3:0] prog_len = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, cfg_en, capture;
  logic [2:0] cfg_inst, global_sel, step_idx;

  int n_checks = 0;
  int n_fails  = 0;

  logic [9:0] shadow [8];

  typedef struct packed {
    logic [12:0] v;
    logic        midx;
  } exp_t;

  ha_cfg_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .abort(abort),
    .busy(busy), .done(done), .cfg_en(cfg_en), .cfg_inst(cfg_inst),
    .global_sel(global_sel), .step_idx(step_idx), .capture(capture)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] pk(input logic b, input logic d, input logic e,
                                     input logic c, input logic [2:0] inst,
                                     input logic [2:0] sel, input logic [2:0] idx);
    return {b, d, e, c, inst, sel, idx};
  endfunction

  function automatic logic [12:0] obs();
    return {busy, done, cfg_en, capture, cfg_inst, global_sel, step_idx};
  endfunction

  function automatic int step_cycles(input logic [9:0] ent);
    int h;
    h = int'(ent[3:0]);
    return ((h < LAT) ? LAT : h) + 2;
  endfunction

  function automatic int prog_cycles(input int len);
    int s;
    s = 0;
    for (int k = 0; k < len; k++) s += step_cycles(shadow[k]);
    return s;
  endfunction

  task automatic write_entry(input int addr, input logic [9:0] data);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 3'(addr);
    prog_data = data;
    @(negedge clk);
    prog_we = 1'b0;
    shadow[addr] = data;
  endtask

  // Runs one program; abort_at is the index of a busy cycle to abort in, or -1.
  task automatic run_program(input int len, input int abort_at, input bit junk, input string tag);
    exp_t       q[$];
    exp_t       e;
    int         n, total, done_cyc;
    logic [2:0] li, ls;
    logic [12:0] got, expv;
    total = 0;
    li = '0;
    ls = '0;
    for (int k = 0; k < len; k++) begin
      li = shadow[k][9:7];
      ls = shadow[k][6:4];
      n  = step_cycles(shadow[k]) - 2;
      e.midx = 1'b0;
      e.v = pk(1'b1, 1'b0, 1'b1, 1'b0, li, ls, 3'(k));
      q.push_back(e);
      for (int r = 0; r <= n; r++) begin
        e.v = pk(1'b1, 1'b0, 1'b0, (r == n), li, ls, 3'(k));
        q.push_back(e);
      end
      total += n + 2;
    end
    e.midx = 1'b1;
    e.v = pk(1'b0, 1'b1, 1'b0, 1'b0, li, ls, 3'd0);
    q.push_back(e);
    e.v = pk(1'b0, 1'b0, 1'b0, 1'b0, li, ls, 3'd0);
    q.push_back(e);
    if (abort_at >= 0) begin
      e  = q[abort_at];
      li = e.v[8:6];
      ls = e.v[5:3];
      q  = q[0:abort_at];
      e.midx = 1'b0;
      e.v = pk(1'b0, 1'b0, 1'b0, 1'b0, li, ls, 3'd0);
      q.push_back(e);
      q.push_back(e);
    end
    @(negedge clk);
    start    = 1'b1;
    prog_len = 4'(len);
    @(negedge clk);
    start = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < q.size(); i++) begin
      got  = obs();
      expv = q[i].v;
      if (q[i].midx) begin
        got[2:0]  = '0;
        expv[2:0] = '0;
      end
      chk($sformatf("%s_c%0d", tag, i + 1), 32'(got), 32'(expv));
      if (done && done_cyc < 0) done_cyc = i + 1;
      abort = (i == abort_at);
      if (junk && (q[i].v[12] || q[i].v[11])) begin
        start = ($urandom_range(0, 3) == 0);
        if (q[i].v[11]) abort = ($urandom_range(0, 1) == 1);
      end
      if (junk && q[i].v[12] && ($urandom_range(0, 2) == 0)) begin
        prog_we   = 1'b1;
        prog_addr = 3'($urandom_range(0, 7));
        prog_data = 10'($urandom);
      end
      @(negedge clk);
      abort   = 1'b0;
      start   = 1'b0;
      prog_we = 1'b0;
    end
    if (abort_at < 0) chk({tag, "_latency"}, 32'(done_cyc), 32'(total + 1));
    else              chk({tag, "_nodone"}, 32'(done_cyc), 32'hFFFF_FFFF);
    $display("txn %s len=%0d abort_at=%0d cycles=%0d", tag, len, abort_at, done_cyc);
  endtask

  initial begin
    int len, ab, n0;
    for (int k = 0; k < 8; k++) shadow[k] = '0;
    #1 rst = 1'b1;
    #1 chk("reset_outputs", 32'(obs()), 32'd0);
    repeat (2) @(negedge clk);
    chk("reset_hold", 32'(obs()), 32'd0);
    rst = 1'b0;

    // Illegal lengths must be ignored.
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      start    = 1'b1;
      prog_len = (t == 0) ? 4'd0 : 4'd9;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("guard_len%0d_c%0d", prog_len, c), 32'({busy, done}), 32'd0);
        @(negedge clk);
      end
      $display("txn guard prog_len=%0d", prog_len);
    end

    write_entry(0, {3'b101, 3'b010, 4'd2});
    run_program(1, -1, 1'b0, "single");

    write_entry(0, {3'b001, 3'b011, 4'd0});
    write_entry(1, {3'b010, 3'b110, 4'd0});
    write_entry(2, {3'b100, 3'b001, 4'd0});
    run_program(3, -1, 1'b0, "three");

    for (int k = 0; k < 4; k++) write_entry(k, {6'($urandom), 4'($urandom_range(0, 4))});
    n0 = step_cycles(shadow[0]);
    run_program(4, n0 + 1, 1'b0, "abort_step1");

    run_program(4, -1, 1'b1, "junk_busy");
    run_program(4, -1, 1'b0, "readback");

    for (int k = 0; k < 8; k++) write_entry(k, {6'($urandom), 4'd15});
    run_program(8, -1, 1'b0, "full");

    for (int it = 0; it < 16; it++) begin
      for (int w = 0; w < int'($urandom_range(1, 8)); w++) begin
        write_entry(int'($urandom_range(0, 7)), {6'($urandom), 4'($urandom_range(0, 6))});
      end
      len = int'($urandom_range(1, 8));
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, prog_cycles(len) - 1)) : -1;
      run_program(len, ab, 1'b1, $sformatf("rand%0d", it));
    end

    // Asynchronous reset in the middle of a RUN phase.
    for (int k = 0; k < 3; k++) write_entry(k, {6'($urandom), 4'd5});
    @(negedge clk);
    start    = 1'b1;
    prog_len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst_now", 32'(obs()), 32'd0);
    for (int k = 0; k < 8; k++) shadow[k] = '0;
    @(negedge clk);
    chk("async_rst_hold", 32'(obs()), 32'd0);
    rst = 1'b0;
    $display("txn async_reset");
    write_entry(0, {3'b110, 3'b101, 4'd3});
    run_program(1, -1, 1'b0, "post_rst");
    run_program(2, -1, 1'b0, "post_rst_cleared");

    $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
    $finish;
  end

endmodule
